dmem_arbiter: RTL and testbench

Sequencing arbiter for the single data-memory port of the miniRISC datapath. It shares that port between the processor's load/store path and the board-level host read path (button plus address switches). It issues one memory access at a time through a three-state FSM and returns a one-cycle acknowledge to the winning requester. The processor has fixed priority, and a bounded-wait counter guarantees the host is eventually served.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/arb_wait_counter.sv | 28 ++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Used by dmem_arbiter and arb_wait_counter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF        = 10;
    localparam int DATA_W_DEF        = 32;
    localparam int HOST_MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_HOST
    } gnt_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating host-age counter: counts lost arbitrations up to max.
// reached tells the arbiter the host must win the next contested grant.
module arb_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic         reached
);

    logic [W-1:0] cnt;

    assign reached = (cnt >= max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !reached) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority, bounded host wait, 3-cycle access.
// Optional DMEM_ARB_ALIGN_CHECK_EN blocks misaligned CPU accesses and flags cpu_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);

    state_t state_q;
    state_t state_d;
    gnt_t   gnt;
    logic   gnt_we;
    logic   gnt_bad;
    logic   take;
    logic   host_win;
    logic   reached;
    logic   bad_d;
    logic   in_resp;

    arb_wait_counter #(
        .W(CW)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .inc    (take && cpu_req && host_req && !host_win),
        .clr    (take && host_win),
        .max    (CW'(HOST_MAX_WAIT)),
        .reached(reached)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        host_win = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || host_req) begin
                    take     = 1'b1;
                    host_win = host_req && (!cpu_req || reached);
                    state_d  = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic err_q;
    logic unused_addr;

    assign bad_d       = !host_win && (cpu_addr[1:0] != 2'b00);
    assign unused_addr = ^cpu_addr[31:ADDR_W+2];
    assign cpu_err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               err_q <= 1'b0;
        else if (take && bad_d) err_q <= 1'b1;
    end
`else
    logic unused_addr;

    assign bad_d       = 1'b0;
    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
    assign cpu_err     = 1'b0;
`endif

    // mem_en/mem_we pulse for the ACCESS cycle only; addr/wdata hold the grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= GNT_CPU;
            gnt_we    <= 1'b0;
            gnt_bad   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (take) begin
                gnt     <= host_win ? GNT_HOST : GNT_CPU;
                gnt_we  <= !host_win && cpu_we;
                gnt_bad <= bad_d;
                mem_en  <= !bad_d;
                mem_we  <= !host_win && cpu_we && !bad_d;
                if (host_win) begin
                    mem_addr  <= host_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_addr  <= cpu_addr[ADDR_W+1:2];
                    mem_wdata <= cpu_wdata;
                end
            end
        end
    end

    assign in_resp = (state_q == RESP);

    always_comb begin
        cpu_ack    = in_resp && (gnt == GNT_CPU);
        host_ack   = in_resp && (gnt == GNT_HOST);
        cpu_rdata  = '0;
        host_rdata = '0;
        if (cpu_ack && !gnt_we && !gnt_bad) cpu_rdata = mem_rdata;
        if (host_ack)                       host_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases then random traffic
// checked against a transaction-level arbitration/memory model.
module tb_dmem_arbiter;

    localparam int HMW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        host_req;
    logic [9:0]  host_addr;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_clr;

    logic [31:0] mem    [1024];
    logic [31:0] shadow [1024];
    int          wcnt;
    logic        err;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(10),
        .DATA_W(32),
        .HOST_MAX_WAIT(HMW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // synchronous RAM stub with one-cycle read latency
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // one arbitration round, entered and left at a negedge in IDLE
    task automatic txn(input logic c, input logic h, input logic we,
                       input logic [31:0] ca, input logic [31:0] wd,
                       input logic [9:0] ha, output logic got_host);
        logic        hw;
        logic        bad;
        logic [9:0]  ea;
        logic [31:0] ed;
        cpu_req   = c;
        cpu_we    = we;
        cpu_addr  = ca;
        cpu_wdata = wd;
        host_req  = h;
        host_addr = ha;
        hw = h && (!c || wcnt >= HMW);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        bad = !hw && (ca % 4 != 0);
`else
        bad = 1'b0;
`endif
        ea = hw ? ha : 10'((ca / 4) % 1024);
        ed = (bad || (!hw && we)) ? 32'h0 : shadow[ea];
        @(negedge clk);
        chk("access_en", mem_en, !bad);
        chk("access_noack", {cpu_ack, host_ack}, 0);
        if (!bad) begin
            chk("access_addr", mem_addr, ea);
            chk("access_we", mem_we, !hw && we);
            if (!hw && we) chk("access_wdata", mem_wdata, wd);
        end
        @(negedge clk);
        chk("cpu_ack", cpu_ack, !hw);
        chk("host_ack", host_ack, hw);
        if (hw) chk("host_rdata", host_rdata, ed);
        else    chk("cpu_rdata", cpu_rdata, ed);
        if (!hw && we && !bad) shadow[ea] = wd;
        if (hw)     wcnt = 0;
        else if (h) wcnt = (wcnt < HMW) ? wcnt + 1 : HMW;
        if (bad)    err = 1'b1;
        chk("cpu_err", cpu_err, err);
        got_host = host_ack;
        if (hw) host_req = 1'b0;
        else    cpu_req  = 1'b0;
        @(negedge clk);
    endtask

    logic        who;
    logic        order [10];
    logic        c;
    logic        h;
    logic        we;
    logic [31:0] ca;
    logic [31:0] wd;
    logic [9:0]  ha;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        wcnt      = 0;
        err       = 1'b0;
        rst       = 1'b0;
        mem_clr   = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        host_req  = 1'b0;
        host_addr = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_cpu_err", cpu_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst     = 1'b1;
        mem_clr = 1'b0;

        txn(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, who);
        txn(1, 0, 0, 32'h0000_0010, 32'h0, 0, who);
        txn(0, 1, 0, 32'h0, 32'h0, 10'd4, who);

        for (int i = 0; i < 10; i++) begin
            txn(1, 1, 0, 32'h0000_0010, 32'h0, 10'd4, who);
            chk($sformatf("order_%0d", i), who, order[i]);
        end

        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0010;
        host_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_en", mem_en, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_en", mem_en, 0);
        cpu_req = 1'b0;
        #1;
        rst  = 1'b1;
        wcnt = 0;
        err  = 1'b0;
        @(negedge clk);
        chk("post_rst_cpu_ack", cpu_ack, 0);
        chk("post_rst_host_ack", host_ack, 0);
        chk("post_rst_en", mem_en, 0);
        txn(1, 0, 0, 32'h0000_0010, 32'h0, 0, who);

        txn(1, 0, 0, 32'h0000_0013, 32'h0, 0, who);
        txn(0, 1, 0, 32'h0, 32'h0, 10'd4, who);

        for (int i = 0; i < 60; i++) begin
            if (cpu_req) begin
                c  = 1'b1;
                we = cpu_we;
                ca = cpu_addr;
                wd = cpu_wdata;
            end else begin
                c  = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1));
                ca = $urandom;
                ca[11:2] = 10'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) ca[1:0] = 2'b00;
                wd = $urandom;
            end
            if (host_req) begin
                h  = 1'b1;
                ha = host_addr;
            end else begin
                h  = 1'($urandom_range(0, 1));
                ha = 10'($urandom_range(0, 15));
            end
            if (!c && !h) c = 1'b1;
            txn(c, h, we, ca, wd, ha, who);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
